// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that lets NUM_REQ byte sources share
// one UART transmit FIFO. The winner holds the channel until its message ends,
// LOCK_MAX bytes have gone through, or (timeout build) it sits idle for TIMEOUT cycles.
// Optional feature macro: UART_ARB_TIMEOUT_EN (idle-owner forced release).
module uart_tx_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int LOCK_MAX = 64,
    parameter int TIMEOUT  = 1024
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [NUM_REQ*8-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [7:0]           tx_data_o,
    output logic                 tx_valid_o,
    input  logic                 tx_ready_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 busy_o
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state;
    logic [IW-1:0] owner;
    logic [IW-1:0] ptr;
    logic [IW-1:0] sel;
    logic [IW:0]   scan;
    logic          found;
    logic [7:0]    burst_cnt;
    logic [7:0]    cnt_next;
    logic          slot_free;
    logic          xfer;
    logic          hit_max;
    logic          release_now;
    logic          timeout_hit;
    logic [IW-1:0] next_ptr;
    logic [7:0]    owner_byte;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [TW-1:0] idle_cnt;
    // The owner has been silent for TIMEOUT cycles once this cycle is counted.
    assign timeout_hit = (state == LOCKED) && !req_valid_i[owner] &&
                         (idle_cnt == TW'(TIMEOUT - 1));
`else
    // Without the timeout build the owner is never pre-empted for silence;
    // TIMEOUT is legal-range only, so this comparison folds to zero.
    assign timeout_hit = (TIMEOUT < 0);
`endif

    // The output register can take a byte when it is empty or draining this cycle.
    assign slot_free   = !tx_valid_o || tx_ready_i;
    assign owner_byte  = req_data_i[{owner, 3'b000} +: 8];
    assign xfer        = (state == LOCKED) && req_valid_i[owner] && slot_free;
    assign cnt_next    = burst_cnt + 8'd1;
    assign hit_max     = (cnt_next == 8'(LOCK_MAX));
    assign release_now = (xfer && (req_last_i[owner] || hit_max)) || timeout_hit;
    assign next_ptr    = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign busy_o      = (state == LOCKED) || tx_valid_o;

    // Round-robin pick: first valid requester scanning from ptr upward, wrapping.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        scan  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan = {1'b0, ptr} + (IW + 1)'(k);
            if (scan >= (IW + 1)'(NUM_REQ)) begin
                scan = scan - (IW + 1)'(NUM_REQ);
            end
            if (req_valid_i[scan[IW-1:0]]) begin
                sel   = scan[IW-1:0];
                found = 1'b1;
            end
        end
    end

    // Only the owner sees ready, and only while LOCKED with room in the output register.
    always_comb begin
        req_ready_o = '0;
        if ((state == LOCKED) && slot_free) begin
            req_ready_o[owner] = 1'b1;
        end
    end

    // Arbitration FSM, burst accounting and the registered output byte.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state      <= IDLE;
            owner      <= '0;
            ptr        <= '0;
            burst_cnt  <= '0;
            grant_o    <= '0;
            tx_data_o  <= 8'h00;
            tx_valid_o <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            idle_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= LOCKED;
                        owner     <= sel;
                        grant_o   <= NUM_REQ'(1) << sel;
                        burst_cnt <= '0;
`ifdef UART_ARB_TIMEOUT_EN
                        idle_cnt  <= '0;
`endif
                    end
                end
                LOCKED: begin
                    if (xfer) begin
                        burst_cnt <= cnt_next;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    if (req_valid_i[owner]) begin
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
`endif
                    if (release_now) begin
                        state   <= IDLE;
                        grant_o <= '0;
                        ptr     <= next_ptr;
                    end
                end
                default: state <= IDLE;
            endcase

            // A new byte replaces a draining one in the same cycle (full throughput).
            if (xfer) begin
                tx_data_o  <= owner_byte;
                tx_valid_o <= 1'b1;
            end else if (tx_ready_i) begin
                tx_valid_o <= 1'b0;
            end
        end
    end
endmodule
